uart_tx_responder: RTL and testbench
====================================

// Module: uart_tx_responder
// PURPOSE
//  Memory-mapped UART transmitter. It is the bus responder to the CPU's peripheral rd/wr/addr/wdata/rdata interface.
//  The CPU writes bytes into a small TX FIFO. The block serializes them onto UART_TX as 8N1 frames, LSB first.
//  Status and the interrupt request (irqout) feed the CPU's peripheral read mux and IRQ logic.
// PARAMETERS
//  BAUD_DIV    5208           sysclk cycles per UART bit (50 MHz / 9600 baud)
//  FIFO_DEPTH  4              TX FIFO entries; power of two, >= 2
//  BASE_ADDR   32'h40000018   byte address of TXDATA; TXCTRL is at BASE_ADDR+4
// PORTS
//  sysclk   in   1   clock; all state updates on rising edge
//  reset    in   1   synchronous, active-high reset
//  rd       in   1   CPU read strobe
//  wr       in   1   CPU write strobe, sampled on rising sysclk
//  addr     in   32  CPU byte address
//  wdata    in   32  CPU write data
//  rdata    out  32  read data (combinational)
//  UART_TX  out  1   serial output, idle high, registered
//  irqout   out  1   interrupt request, level, registered
// BEHAVIOUR
//  Reset (sync, active-high; one clock cycle sets all of the following on the next edge):
//   UART_TX=1, irqout=0, FIFO flushed (count=0), state=IDLE, baud counter=0, irq_en=0, done=0, ovf=0.
//   Reset asserted mid-frame aborts the frame; UART_TX=1 after that edge.
//  Register map (exact 32-bit address match; other addresses are ignored):
//   TXDATA  BASE+0  W: push wdata[7:0] into FIFO.  R: 0.
//   TXCTRL  BASE+4  R: [0]irq_en [1]busy [2]full [3]empty [4]done [5]ovf [10:8]count; other bits 0.
//                   W: [0]->irq_en; [4]=1 clears done; [5]=1 clears ovf (W1C).
//  rdata = (rd & addr hit) ? register value : 32'h0.
//  busy = (state != IDLE).
//  FIFO: circular buffer; read/write pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
//   Push while full with no pop that cycle: byte dropped, ovf<=1, FIFO unchanged.
//   Push while full with a pop the same cycle: byte accepted, count unchanged.
//   Push while empty: the serializer pops no earlier than the next cycle; there is no bypass.
//  Serializer FSM; each of START/DATA/STOP bits is held for exactly BAUD_DIV cycles:
//   IDLE : FIFO non-empty -> pop into shift reg, UART_TX<=0, go to START.
//   START: after BAUD_DIV cycles -> UART_TX<=bit0, go to DATA, bit index=0.
//   DATA : every BAUD_DIV cycles shift the next bit out; after bit7 -> UART_TX<=1, go to STOP.
//   STOP : after BAUD_DIV cycles:
//           FIFO non-empty -> pop, UART_TX<=0, go to START (back-to-back, no idle gap).
//           else -> go to IDLE and set done<=1.
//  Latency: a write at edge k drives UART_TX low at edge k+1. A frame is 10*BAUD_DIV cycles.
//  done and the ovf-clear W1C: a set event (done or ovf) and a W1C clear in the same cycle -> set wins.
//  irqout <= irq_en & done, registered; deasserts the edge after done is cleared or irq_en is cleared.
// TESTING (bench uses BAUD_DIV=4, FIFO_DEPTH=4, BASE_ADDR=32'h40000018)
//  1. After reset, read TXCTRL -> 32'h0000_0008 (empty); UART_TX=1, irqout=0.
//  2. Write 8'hA5 to TXDATA at edge 0. Required:
//     UART_TX=0 during cycles 1-4; bits 1,0,1,0,0,1,0,1 in 4-cycle slots; stop bit high in cycles 37-40;
//     after that TXCTRL[4]=1.
//  3. Write irq_en=1, then one byte -> irqout=1 one edge after done sets.
//     Write TXCTRL=32'h11 -> irqout=0 next edge; irq_en stays 1.
//  4. Burst: write 5 bytes in 5 consecutive cycles while IDLE. Required:
//     first byte popped, remaining 4 fill the FIFO, no ovf. All 5 frames sent back-to-back, 200 cycles, no gap.
//  5. Fill FIFO during a frame (count=4), write a 6th byte -> dropped, ovf=1, count=4.
//     Write TXCTRL[5]=1 -> ovf=0.
//  6. Assert reset mid-DATA -> UART_TX=1 next edge, count=0, state IDLE, irq_en=0. No further frame bits appear.

Source files
------------

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with a small TX FIFO, status register and level IRQ
// Ports:
//   sysclk  - clock, all state updates on the rising edge
//   reset   - synchronous active-high reset
//   rd, wr  - CPU read / write strobes
//   addr    - CPU byte address (exact match on TXDATA = BASE_ADDR, TXCTRL = BASE_ADDR+4)
//   wdata   - CPU write data
//   rdata   - combinational read data, zero unless a read hits TXCTRL
//   UART_TX - registered serial output, idle high
//   irqout  - registered level interrupt, irq_en & done
module uart_tx_responder #(
    parameter int          BAUD_DIV   = 5208,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        UART_TX,
    output logic        irqout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   baud;
    logic [2:0]      idx, idx_nx;
    logic [7:0]      sh, sh_nx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rptr, wptr;
    logic [CW-1:0]   count;
    logic [2:0]      count3;
    logic            irq_en, done, ovf;
    logic            empty, full, tick, pop, push, tx_nx, done_set, ovf_set;
    logic            hit_data, hit_ctrl, ctrl_wr;
    logic            unused_wdata;

    assign hit_data     = addr == BASE_ADDR;
    assign hit_ctrl     = addr == BASE_ADDR + 32'd4;
    assign ctrl_wr      = wr && hit_ctrl;
    assign empty        = count == '0;
    assign full         = count == CW'(FIFO_DEPTH);
    assign tick         = baud == BW'(BAUD_DIV - 1);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted
    assign push         = wr && hit_data && (!full || pop);
    assign ovf_set      = wr && hit_data && full && !pop;
    assign count3       = 3'(count);
    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge sysclk) begin
        state <= reset ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : START;
            START:   state_nx = tick ? DATA : START;
            DATA:    state_nx = (tick && idx == 3'd7) ? STOP : DATA;
            default: state_nx = !tick ? STOP : (empty ? IDLE : START);
        endcase
    end

    // Pops only happen from IDLE or at the end of a stop bit, which gives back-to-back frames
    always_comb begin
        pop      = !empty && (state == IDLE || (state == STOP && tick));
        done_set = state == STOP && tick && empty;
        tx_nx    = pop ? 1'b0 :
                   !tick ? UART_TX :
                   state == START ? sh[0] :
                   state == DATA ? (idx == 3'd7 ? 1'b1 : sh[0]) :
                   state == STOP ? 1'b1 : UART_TX;
        sh_nx    = pop ? mem[rptr] : (tick && (state == START || state == DATA)) ? sh >> 1 : sh;
        idx_nx   = state == START ? 3'd0 : (state == DATA && tick) ? idx + 3'd1 : idx;
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wptr] <= wdata[7:0];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            UART_TX <= 1'b1;
            irqout  <= 1'b0;
            baud    <= '0;
            idx     <= '0;
            sh      <= '0;
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            UART_TX <= tx_nx;
            irqout  <= irq_en & done;
            baud    <= (state == IDLE || tick) ? '0 : baud + BW'(1);
            idx     <= idx_nx;
            sh      <= sh_nx;
            rptr    <= rptr + AW'(pop);
            wptr    <= wptr + AW'(push);
            count   <= count + CW'(push) - CW'(pop);
            irq_en  <= ctrl_wr ? wdata[0] : irq_en;
            // Set events win over a simultaneous write-one-to-clear
            done    <= done_set | (done & !(ctrl_wr & wdata[4]));
            ovf     <= ovf_set | (ovf & !(ctrl_wr & wdata[5]));
        end
    end

    always_comb begin
        rdata = (rd && hit_ctrl) ?
                {21'd0, count3, 2'd0, ovf, done, empty, full, state != IDLE, irq_en} : 32'h0;
    end
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: directed scoreboard bench for uart_tx_responder with a serial frame monitor
module tb_uart_tx_responder;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] CTRL = BASE + 32'd4;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] rdata;
    logic        UART_TX;
    logic        irqout;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    logic [7:0] exp_q[$];
    int   starts[$];
    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;
    logic [7:0] mon_rx, mon_e;
    logic mon_ok, mon_v, mon_sv;
    int   mon_st;

    uart_tx_responder #(.BAUD_DIV(4), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .UART_TX(UART_TX), .irqout(irqout)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge sysclk);
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        rd = 1'b0; addr = '0;
    endtask

    task automatic wait_drain(input int lim);
        int i;
        for (i = 0; i < lim && (exp_q.size() != 0 || mon_busy); i++) @(negedge sysclk);
        check("drain", {31'd0, i < lim}, 32'd1);
    endtask

    // Frame monitor: samples every cycle of a frame, requires each bit stable for 4 cycles
    initial forever begin
        @(negedge sysclk);
        if (mon_en && UART_TX === 1'b0) begin
            mon_busy = 1'b1; mon_st = cyc; mon_ok = 1'b1; mon_rx = '0;
            for (int s = 0; s < 10; s++) begin
                for (int c = 0; c < 4; c++) begin
                    if (s != 0 || c != 0) @(negedge sysclk);
                    mon_v = UART_TX;
                    if (c == 0) mon_sv = mon_v;
                    else if (mon_v !== mon_sv) mon_ok = 1'b0;
                end
                if (s == 0 && mon_sv !== 1'b0) mon_ok = 1'b0;
                if (s == 9 && mon_sv !== 1'b1) mon_ok = 1'b0;
                if (s >= 1 && s <= 8) mon_rx[s-1] = mon_sv;
            end
            starts.push_back(mon_st);
            check("frame_shape", {31'd0, mon_ok}, 32'd1);
            check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("frame_byte", {24'd0, mon_rx}, {24'd0, mon_e});
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  pat;
        logic [7:0]  burst [6];
        logic        e;
        int          b0, e0, slot, lows;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        // reset state and address decode
        bus_read(CTRL, d);       check("reset_ctrl", d, 32'h8);
        check("reset_tx", {31'd0, UART_TX}, 32'd1);
        check("reset_irq", {31'd0, irqout}, 32'd0);
        bus_read(BASE, d);       check("rd_txdata", d, 32'h0);
        bus_read(BASE + 8, d);   check("rd_miss", d, 32'h0);
        addr = CTRL; #1 check("rd_idle", rdata, 32'h0); addr = '0;
        // single byte, exact cycle timing
        pat = 8'hA5;
        exp_q.push_back(pat);
        bus_write(BASE, 32'hA5);
        for (int c = 0; c <= 41; c++) begin
            if (c > 0) @(negedge sysclk);
            slot = (c - 1) / 4;
            e = (c == 0 || c == 41) ? 1'b1 : slot == 0 ? 1'b0 : slot <= 8 ? pat[slot-1] : 1'b1;
            check("t2_tx", {31'd0, UART_TX}, {31'd0, e});
            if (c == 40) begin bus_read(CTRL, d); check("t2_busy", d, 32'h0A); end
            if (c == 41) begin bus_read(CTRL, d); check("t2_done", d, 32'h18); end
        end
        // interrupt
        bus_write(CTRL, 32'h11);
        bus_read(CTRL, d);       check("t3_en", d, 32'h09);
        exp_q.push_back(8'h3C);
        bus_write(BASE, 32'h3C);
        repeat (41) @(negedge sysclk);
        check("t3_irq_pre", {31'd0, irqout}, 32'd0);
        bus_read(CTRL, d);       check("t3_done", d, 32'h19);
        @(negedge sysclk);
        check("t3_irq_set", {31'd0, irqout}, 32'd1);
        bus_write(CTRL, 32'h11);
        check("t3_irq_hold", {31'd0, irqout}, 32'd1);
        @(negedge sysclk);
        check("t3_irq_clr", {31'd0, irqout}, 32'd0);
        bus_read(CTRL, d);       check("t3_ctrl", d, 32'h09);
        // burst of five, back-to-back frames
        starts.delete();
        burst = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h00};
        b0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            if (i == 1) b0 = cyc;
            wr = 1'b1; addr = BASE; wdata = {24'd0, burst[i]};
            exp_q.push_back(burst[i]);
        end
        @(negedge sysclk);
        wr = 1'b0; addr = '0;
        bus_read(CTRL, d);       check("t4_full", d, 32'h407);
        wait_drain(400);
        repeat (2) @(negedge sysclk);
        check("t4_frames", starts.size(), 32'd5);
        if (starts.size() == 5) begin
            check("t4_first", starts[0], b0 + 1);
            for (int i = 1; i < 5; i++) check("t4_gap", starts[i] - starts[i-1], 32'd40);
        end
        bus_read(CTRL, d);       check("t4_done", d, 32'h19);
        check("t4_irq", {31'd0, irqout}, 32'd1);
        bus_write(CTRL, 32'h30);
        // overflow while full
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        e0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            if (i == 1) e0 = cyc;
            wr = 1'b1; addr = BASE; wdata = {24'd0, burst[i]};
            if (i < 5) exp_q.push_back(burst[i]);
        end
        @(negedge sysclk);
        wr = 1'b0; addr = '0;
        check("t5_cycle", cyc, e0 + 5);
        bus_read(CTRL, d);       check("t5_ovf", d, 32'h426);
        bus_write(CTRL, 32'h20);
        bus_read(CTRL, d);       check("t5_ovf_clr", d, 32'h406);
        wait_drain(400);
        repeat (2) @(negedge sysclk);
        bus_read(CTRL, d);       check("t5_end", d, 32'h18);
        bus_write(CTRL, 32'h31);
        // reset mid-frame
        mon_en = 1'b0;
        bus_write(BASE, 32'hC3);
        repeat (12) @(negedge sysclk);
        bus_read(CTRL, d);       check("t6_busy", d, 32'h0B);
        reset = 1'b1;
        @(negedge sysclk);
        check("t6_tx", {31'd0, UART_TX}, 32'd1);
        check("t6_irq", {31'd0, irqout}, 32'd0);
        bus_read(CTRL, d);       check("t6_ctrl", d, 32'h08);
        reset = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1) lows++;
        end
        check("t6_quiet", lows, 32'd0);
        bus_read(CTRL, d);       check("t6_idle", d, 32'h08);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
